clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Parametrised multi-channel clock divider for the VGA/display clocking path. From the single master clock it produces, per channel, a one-cycle clock-enable strobe and a registered square wave. Each channel has its own divisor, which can be reprogrammed at run time without glitches. Downstream logic stays on `clk` and qualifies with `tick_o[i]`; it never clocks from a divided signal. Default configuration gives the 25 MHz pixel enable from a 100 MHz master (divide by 4).

## Interface
- `N_CH`, 4: number of independent channels (1–16).
- `DIV_W`, 8: divisor and counter width in bits.
- `DEFAULT_DIV`, 4: divisor loaded into every channel at reset. Must fit in `DIV_W`.
- `clk`, in, 1: master clock (100 MHz).
- `rst_n`, in, 1: reset, asynchronous, active-low. All state clears immediately on assertion; release is synchronous to `clk`.
- `en_i`, in, 1: global run enable.
- `sync_i`, in, 1: phase-align strobe; restarts all channels together.
- `cfg_we_i`, in, 1: divisor write strobe.
- `cfg_sel_i`, in, max(1,$clog2(N_CH)): channel index for the write.
- `cfg_div_i`, in, DIV_W: new divisor value.
- `tick_o`, out, N_CH: one-cycle enable strobe per channel.
- `sq_o`, out, N_CH: divided square wave per channel, registered.
- `pend_o`, out, N_CH: a divisor write is pending on that channel.

## Operation
- Per-channel registers:
  - `div[i]` (DIV_W): active divisor.
  - `cnt[i]` (DIV_W): phase counter.
  - `pend[i]` (DIV_W): pending divisor value.
  - `pv[i]`: pending-valid flag.
  - `tick_o[i]`, `sq_o[i]`.
- Reset values: `div = DEFAULT_DIV`; `cnt = 0`; `pv = 0`; `pend = 0`; `tick_o = 0`; `sq_o = 0`; `pend_o = 0`.
- Counting, for `div ≥ 1` and `en_i = 1`:
  - `cnt` counts 0 … `div-1`, then wraps to 0.
  - `tick_o` is registered `(cnt == div-1)`, so it is high in the cycle after the wrap edge.
  - `sq_o` is registered `(cnt_next < div>>1)`. For even `div` it is high for `div/2` cycles; for odd `div` it is high for `floor(div/2)` cycles.
- `div == 1`: `tick_o` is constantly 1 and `sq_o` is constantly 0.
- `div == 0`: channel disabled. `cnt` is held at 0, `tick_o = 0`, `sq_o = 0`.
- `en_i = 0`:
  - `cnt`, `sq_o` and `div` hold their values.
  - `tick_o` is forced to 0.
  - Config writes are still captured into `pend`. Pending values are applied only while `en_i = 1` (at a wrap or on `sync_i`), except on disabled channels (see below).
- Write:
  - `cfg_we_i` with `cfg_sel_i < N_CH` loads `pend[sel] = cfg_div_i` and sets `pv[sel] = 1`.
  - `cfg_sel_i ≥ N_CH`: the write is ignored.
  - A later write overwrites an earlier pending value; last write wins.
- Apply: at an edge where `pv[i] = 1` and either (a) `cnt[i] == div[i]-1` with `en_i = 1`, or (b) `div[i] == 0`:
  - `div[i] ← pend[i]`, `cnt[i] ← 0`, `pv[i] ← 0`.
  - `tick_o` for that edge follows case (a) (the old period completed). In case (b) `tick_o` stays 0.
- Write coinciding with an apply edge on the same channel: the incoming `cfg_div_i` is applied directly (bypass) and `pv` ends at 0.
- `sync_i` at an edge with `en_i = 1`, for all channels:
  - Apply any pending divisor.
  - `cnt ← 0`, `tick_o ← 0`, `sq_o ← (0 < div_new>>1)`.
  - `sync_i` has priority over normal counting and wrap.
- `pend_o = pv`.

## Timing
- After `rst_n` release, the first `tick_o[i]` is high in the cycle following rising edge number `DEFAULT_DIV`. After that the period is exactly `div` cycles.
- `sq_o` during the first partial period after reset is low for the reset cycle only; from edge 1 onward it follows the formula.
- Divisor change latency: the new period starts at the first wrap edge after the write (at most `div_old` cycles). The old period always completes, so no runt or stretched `tick_o` or `sq_o` pulse is ever produced.
- Disabled channel (`div == 0`) picks up a write at the next edge. Its first tick arrives `div_new` edges after that.
- `sync_i`: the cycle after the sync edge has `cnt = 0` on all channels. All channels with equal `div` tick on the same cycle from then on.
- Reset assertion mid-period clears everything asynchronously. Pending writes are lost and `div` returns to `DEFAULT_DIV`.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, defaults (N_CH=4, DEFAULT_DIV=4), `en_i=1` for 40 cycles -> `tick_o` = 4'hF on the cycles after edges 4, 8, 12, …; `sq_o` 2 cycles high / 2 low; `pend_o = 0`.
- Write ch1 = 10 when `cnt[1] = 1` -> `pend_o[1]=1`; ch1 completes its 4-cycle period; then ticks every 10 cycles; `sq_o[1]` 5 high / 5 low; `pend_o[1]` clears at the wrap edge. Other channels are unaffected.
- Write ch2 = 0, then ch2 = 1, then ch3 = 7 -> ch2 goes silent after its current period; ch2 then ticks every cycle with `sq_o[2]=0`; ch3 ticks every 7 cycles with `sq_o[3]` 3 high / 4 low.
- Channels set to 5, 5, 3, 6 and free-running; pulse `sync_i` -> the next cycle all `cnt = 0`, `tick_o = 0`; ch0 and ch1 tick together 5 edges later; a pending write on ch3 (=8) is applied at the sync edge.
- Hold `en_i=0` for 6 cycles mid-period and write ch0 = 9 -> `tick_o = 0`, `sq_o` frozen, `pend_o[0]=1`; after re-enable the old period completes, then period 9.
- Assert `rst_n=0` asynchronously mid-period with `pv` set -> all outputs 0 immediately with no clock edge; after release, period 4 on all channels and `pend_o = 0`.

Source files
------------

// File: rtl/clock_enable_gen_if.sv
// Control and strobe bundle for clock_enable_gen. The master drives run, sync
// and divisor-write controls. The slave returns per-channel tick, square and pending flags.
interface clock_enable_gen_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 8,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic             en_i;
  logic             sync_i;
  logic             cfg_we_i;
  logic [SEL_W-1:0] cfg_sel_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic [N_CH-1:0]  tick_o;
  logic [N_CH-1:0]  sq_o;
  logic [N_CH-1:0]  pend_o;

  modport master (
    output en_i, sync_i, cfg_we_i, cfg_sel_i, cfg_div_i,
    input  tick_o, sq_o, pend_o
  );

  modport slave (
    input  en_i, sync_i, cfg_we_i, cfg_sel_i, cfg_div_i,
    output tick_o, sq_o, pend_o
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel divisor, one-cycle tick,
// registered square wave, and glitch-free divisor changes that take effect at period boundaries.
module clock_enable_gen #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_enable_gen_if.slave  bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  wire logic [N_CH-1:0] w_tick;
  wire logic [N_CH-1:0] w_sq;
  wire logic [N_CH-1:0] w_pend;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_div, r_cnt, r_pend;
    logic             r_pv, r_tick, r_sq;

    logic [DIV_W-1:0] w_div_nxt, w_cnt_nxt, w_pend_nxt, w_new, w_tgt;
    logic             w_pv_nxt, w_tick_nxt, w_sq_nxt;
    logic             w_wr, w_zero, w_wrap;

    // Selects outside 0..N_CH-1 match no channel, so those writes are dropped.
    assign w_wr   = bus.cfg_we_i && (bus.cfg_sel_i == SEL_W'(g));
    // A write landing on an apply edge bypasses the pending register.
    assign w_new  = w_wr ? bus.cfg_div_i : r_pend;
    assign w_zero = (r_div == '0);
    assign w_wrap = !w_zero && (r_cnt == r_div - 1'b1);

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_div_nxt  = r_div;
      w_cnt_nxt  = r_cnt;
      w_pend_nxt = w_new;
      w_pv_nxt   = r_pv | w_wr;
      w_tick_nxt = 1'b0;
      w_sq_nxt   = r_sq;
      w_tgt      = r_div;

      if (w_zero && r_pv) begin
        // Disabled channel adopts its pending divisor regardless of en_i.
        w_div_nxt = w_new;
        w_cnt_nxt = '0;
        w_pv_nxt  = 1'b0;
        w_sq_nxt  = bus.en_i && ((w_new >> 1) != '0);
      end else if (bus.en_i) begin
        if (bus.sync_i) begin
          if (r_pv) begin
            w_tgt     = w_new;
            w_div_nxt = w_new;
            w_pv_nxt  = 1'b0;
          end
          w_cnt_nxt = '0;
          w_sq_nxt  = ((w_tgt >> 1) != '0);
        end else if (w_zero) begin
          w_cnt_nxt = '0;
          w_sq_nxt  = 1'b0;
        end else if (w_wrap && r_pv) begin
          w_div_nxt  = w_new;
          w_cnt_nxt  = '0;
          w_pv_nxt   = 1'b0;
          w_tick_nxt = 1'b1;
          w_sq_nxt   = ((w_new >> 1) != '0);
        end else begin
          w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
          w_tick_nxt = w_wrap;
          w_sq_nxt   = (w_cnt_nxt < (r_div >> 1));
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div  <= DIV_W'(DEFAULT_DIV);
        r_cnt  <= '0;
        r_pend <= '0;
        r_pv   <= 1'b0;
        r_tick <= 1'b0;
        r_sq   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every channel register sampling pre-edge values.
        r_div  <= w_div_nxt;
        r_cnt  <= w_cnt_nxt;
        r_pend <= w_pend_nxt;
        r_pv   <= w_pv_nxt;
        r_tick <= w_tick_nxt;
        r_sq   <= w_sq_nxt;
      end
    end

    assign w_tick[g] = r_tick;
    assign w_sq[g]   = r_sq;
    assign w_pend[g] = r_pv;
  end

  assign bus.tick_o = w_tick;
  assign bus.sq_o   = w_sq;
  assign bus.pend_o = w_pend;
endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: each scenario task drives stimulus and
// compares tick/sq/pend against hand-derived period formulas every cycle.
module tb_clock_enable_gen;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  clock_enable_gen_if #(.N_CH(4), .DIV_W(8)) bus ();

  clock_enable_gen #(.N_CH(4), .DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values m cycles after a counter restart with divisor d.
  function automatic bit ftick(int m, int d);
    return (m % d) == 0;
  endfunction

  function automatic bit fsq(int m, int d);
    return (m % d) < (d / 2);
  endfunction

  task automatic drive_idle();
    bus.en_i      = 1'b1;
    bus.sync_i    = 1'b0;
    bus.cfg_we_i  = 1'b0;
    bus.cfg_sel_i = 2'd0;
    bus.cfg_div_i = 8'd0;
  endtask

  task automatic drive_wr(int ch, int d);
    bus.cfg_we_i  = 1'b1;
    bus.cfg_sel_i = 2'(ch);
    bus.cfg_div_i = 8'(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] et, es;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.tick_o, bus.sq_o, bus.pend_o} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=000", {bus.tick_o, bus.sq_o, bus.pend_o});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      drive_idle();
      @(negedge clk);
      et = ftick(k, 4) ? 4'hF : 4'h0;
      es = fsq(k, 4) ? 4'hF : 4'h0;
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, 4'h0}) begin
        n_fail++;
        $display("FAIL default_run k=%0d tick=%b/%b sq=%b/%b pend=%b/0000", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o);
      end
    end
  endtask

  task automatic test_div_change();
    logic [3:0] et, es, ep;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive_idle();
      if (k == 2) drive_wr(1, 10);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (c == 1 && k >= 4) begin
          et[c] = ftick(k - 4, 10); es[c] = fsq(k - 4, 10);
        end else begin
          et[c] = ftick(k, 4); es[c] = fsq(k, 4);
        end
      end
      ep = (k == 2 || k == 3) ? 4'b0010 : 4'b0000;
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, ep}) begin
        n_fail++;
        $display("FAIL div_change k=%0d tick=%b/%b sq=%b/%b pend=%b/%b", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o, ep);
      end
    end
  endtask

  task automatic test_zero_one();
    logic [3:0] et, es, ep;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      drive_idle();
      if (k == 2) drive_wr(2, 0);
      if (k == 6) drive_wr(2, 1);
      if (k == 7) drive_wr(3, 7);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        et[c] = ftick(k, 4); es[c] = fsq(k, 4);
      end
      if (k == 4)      begin et[2] = 1'b1; es[2] = 1'b0; end
      else if (k >= 8) begin et[2] = 1'b1; es[2] = 1'b0; end
      else if (k > 4)  begin et[2] = 1'b0; es[2] = 1'b0; end
      if (k >= 8) begin et[3] = ftick(k - 8, 7); es[3] = fsq(k - 8, 7); end
      ep = 4'b0000;
      ep[2] = (k == 2 || k == 3 || k == 6);
      ep[3] = (k == 7);
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, ep}) begin
        n_fail++;
        $display("FAIL zero_one k=%0d tick=%b/%b sq=%b/%b pend=%b/%b", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o, ep);
      end
    end
  endtask

  task automatic test_sync();
    logic [3:0] et, es, ep;
    int d [4];
    int m;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive_idle();
      case (k)
        1:  drive_wr(0, 5);
        2:  drive_wr(1, 5);
        3:  drive_wr(2, 3);
        5:  drive_wr(3, 6);
        14: drive_wr(3, 8);
        6, 16: bus.sync_i = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      d = '{5, 5, 3, (k >= 16) ? 8 : 6};
      for (int c = 0; c < 4; c++) begin
        if (k < 4 || (k < 6 && c == 3)) begin
          et[c] = ftick(k, 4); es[c] = fsq(k, 4);
        end else if (k < 6) begin
          et[c] = ftick(k - 4, d[c]); es[c] = fsq(k - 4, d[c]);
        end else begin
          m = (k >= 16) ? k - 16 : k - 6;
          et[c] = (m > 0) && ftick(m, d[c]); es[c] = fsq(m, d[c]);
        end
      end
      case (k)
        1: ep = 4'b0001;
        2: ep = 4'b0011;
        3: ep = 4'b0111;
        5, 14, 15: ep = 4'b1000;
        default: ep = 4'b0000;
      endcase
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, ep}) begin
        n_fail++;
        $display("FAIL sync k=%0d tick=%b/%b sq=%b/%b pend=%b/%b", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o, ep);
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] et, es, ep;
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      drive_idle();
      if (k >= 2 && k <= 7) bus.en_i = 1'b0;
      if (k == 3) drive_wr(0, 9);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (k == 1) begin
          et[c] = ftick(1, 4); es[c] = fsq(1, 4);
        end else if (k <= 7) begin
          et[c] = 1'b0; es[c] = fsq(1, 4);
        end else if (c == 0 && k >= 10) begin
          et[c] = ftick(k - 10, 9); es[c] = fsq(k - 10, 9);
        end else begin
          et[c] = ftick(k - 6, 4); es[c] = fsq(k - 6, 4);
        end
      end
      ep = (k >= 3 && k <= 9) ? 4'b0001 : 4'b0000;
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, ep}) begin
        n_fail++;
        $display("FAIL enable k=%0d tick=%b/%b sq=%b/%b pend=%b/%b", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o, ep);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] et, es, ep;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      drive_idle();
      case (k)
        1: drive_wr(1, 6);
        2: drive_wr(1, 2);
        3: drive_wr(0, 6);
        4: drive_wr(0, 3);
        default: ;
      endcase
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        et[c] = ftick(k, 4); es[c] = fsq(k, 4);
      end
      if (k >= 4) begin
        et[0] = ftick(k - 4, 3); es[0] = fsq(k - 4, 3);
        et[1] = ftick(k - 4, 2); es[1] = fsq(k - 4, 2);
      end
      case (k)
        1, 2: ep = 4'b0010;
        3:    ep = 4'b0011;
        default: ep = 4'b0000;
      endcase
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, ep}) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d tick=%b/%b sq=%b/%b pend=%b/%b", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o, ep);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] et, es;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive_idle();
      if (k == 5) drive_wr(0, 9);
      @(negedge clk);
    end
    drive_idle();
    n_checks++;
    if ({bus.tick_o, bus.sq_o, bus.pend_o} !== 12'h0F1) begin
      n_fail++;
      $display("FAIL pre_async_reset got=%h exp=0f1", {bus.tick_o, bus.sq_o, bus.pend_o});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.tick_o, bus.sq_o, bus.pend_o} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=000", {bus.tick_o, bus.sq_o, bus.pend_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      drive_idle();
      @(negedge clk);
      et = ftick(k, 4) ? 4'hF : 4'h0;
      es = fsq(k, 4) ? 4'hF : 4'h0;
      n_checks++;
      if ({bus.tick_o, bus.sq_o, bus.pend_o} !== {et, es, 4'h0}) begin
        n_fail++;
        $display("FAIL post_reset k=%0d tick=%b/%b sq=%b/%b pend=%b/0000", k,
                 bus.tick_o, et, bus.sq_o, es, bus.pend_o);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_div_change();
    test_zero_one();
    test_sync();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
